// File: rtl/phy_link_ctrl.sv
// phy_link_ctrl: link-training and traffic sequencer in front of the PHY transmit datapath.
// Latency: 1 cycle from data_in/valid_in to tx_*/recirc_*; state/active/retrain_count move on the transition edge.
// Backpressure: none; each offered word leaves on tx_* (ACTIVE) or recirc_* (any other state), never both, never dropped.
//
// Ports:
//   clk_2f        sole clock, rising edge
//   reset         asynchronous active-high reset
//   valid_in      data_in holds a word this cycle
//   data_in       payload word
//   rx_sync_in    receive sync detector locked (level)
//   tx_data       word to serializer (COM_WORD when idle, 0 in RESET)
//   tx_valid      tx_data is payload
//   recirc_data   diverted word, holds last value
//   recirc_valid  recirc_data carries a word this cycle
//   active        FSM is in ACTIVE
//   state         RESET=0, TRAIN=1, WAIT_SYNC=2, ACTIVE=3
//   retrain_count saturating retrain event count
//
// Optional feature: define PHY_LINK_CTRL_STATS_EN to build the retrain counter;
// without it retrain_count is tied to 0.
module phy_link_ctrl #(
    parameter int                DATA_W       = 32,
    parameter logic [DATA_W-1:0] COM_WORD     = 32'hBCBCBCBC,
    parameter int                IDLE_WORDS   = 4,
    parameter int                SYNC_TIMEOUT = 16,
    parameter int                LOSS_THRESH  = 3
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rx_sync_in,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic [DATA_W-1:0] recirc_data,
    output logic              recirc_valid,
    output logic              active,
    output logic [1:0]        state,
    output logic [7:0]        retrain_count
);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_TRAIN     = 2'd1,
        ST_WAIT_SYNC = 2'd2,
        ST_ACTIVE    = 2'd3
    } state_t;

    // The shared counter is cleared on state entry, so "last" values are N-1.
    localparam logic [7:0] TRAIN_LAST = 8'(IDLE_WORDS - 1);
    localparam logic [7:0] WAIT_LAST  = 8'(SYNC_TIMEOUT - 1);
    localparam logic [7:0] LOSS_LAST  = 8'(LOSS_THRESH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_nxt;
    logic              w_retrain;

    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic [DATA_W-1:0] r_recirc_data;
    logic              r_recirc_valid;
    logic              r_active;

    // ------------------------------------------------------------------
    // FSM state register and shared per-state counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            r_state <= ST_RESET;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The counter means: words sent in TRAIN, cycles
    // waited in WAIT_SYNC, consecutive sync-low cycles in ACTIVE.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 8'd1;
        w_retrain   = 1'b0;

        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_TRAIN;
            end
            ST_TRAIN: begin
                if (r_cnt == TRAIN_LAST) begin
                    w_state_nxt = ST_WAIT_SYNC;
                end
            end
            ST_WAIT_SYNC: begin
                // Sync is tested first so it wins over a coincident timeout.
                if (rx_sync_in) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (r_cnt == WAIT_LAST) begin
                    w_state_nxt = ST_TRAIN;
                    w_retrain   = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (rx_sync_in) begin
                    w_cnt_nxt = 8'd0;
                end else if (r_cnt == LOSS_LAST) begin
                    w_state_nxt = ST_TRAIN;
                    w_retrain   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = 8'd0;
        end
    end

    // ------------------------------------------------------------------
    // Output registers. Routing keys off the current registered state, so
    // the word sampled on the edge entering ACTIVE still goes to recirc and
    // the word sampled on the edge leaving ACTIVE still goes to tx.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            r_tx_data      <= '0;
            r_tx_valid     <= 1'b0;
            r_recirc_data  <= '0;
            r_recirc_valid <= 1'b0;
            r_active       <= 1'b0;
        end else begin
            r_active       <= (w_state_nxt == ST_ACTIVE);
            r_recirc_valid <= valid_in && (r_state != ST_ACTIVE);
            if (r_state == ST_ACTIVE) begin
                r_tx_valid <= valid_in;
                r_tx_data  <= valid_in ? data_in : COM_WORD;
            end else begin
                r_tx_valid <= 1'b0;
                r_tx_data  <= (r_state == ST_RESET) ? '0 : COM_WORD;
                if (valid_in) begin
                    r_recirc_data <= data_in;
                end
            end
        end
    end

`ifdef PHY_LINK_CTRL_STATS_EN
    logic [7:0] r_retrain_cnt;

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            r_retrain_cnt <= 8'd0;
        end else if (w_retrain && (r_retrain_cnt != 8'hFF)) begin
            r_retrain_cnt <= r_retrain_cnt + 8'd1;
        end
    end

    assign retrain_count = r_retrain_cnt;
`else
    logic w_unused_retrain;
    assign w_unused_retrain = w_retrain;
    assign retrain_count    = 8'd0;
`endif

    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign recirc_data  = r_recirc_data;
    assign recirc_valid = r_recirc_valid;
    assign active       = r_active;
    assign state        = r_state;

endmodule

// File: tb/tb_phy_link_ctrl.sv
// tb_phy_link_ctrl: directed pins plus randomized traffic against a behavioural model.
// Latency: model predicts registered outputs one edge after the sampled inputs.
// Backpressure: n/a (bench drives inputs every cycle).
module tb_phy_link_ctrl;

    localparam logic [31:0] COM        = 32'hBCBCBCBC;
    localparam int          IDLE_WORDS = 4;
    localparam int          SYNC_TMO   = 16;
    localparam int          LOSS_TH    = 3;

    logic        clk_2f     = 1'b0;
    logic        reset      = 1'b1;
    logic        valid_in   = 1'b0;
    logic [31:0] data_in    = 32'd0;
    logic        rx_sync_in = 1'b0;

    logic [31:0] tx_data;
    logic        tx_valid;
    logic [31:0] recirc_data;
    logic        recirc_valid;
    logic        active;
    logic [1:0]  state;
    logic [7:0]  retrain_count;

    phy_link_ctrl dut (
        .clk_2f        (clk_2f),
        .reset         (reset),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .rx_sync_in    (rx_sync_in),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .recirc_data   (recirc_data),
        .recirc_valid  (recirc_valid),
        .active        (active),
        .state         (state),
        .retrain_count (retrain_count)
    );

    always #5 clk_2f = ~clk_2f;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: the mode the link is in, how long it has been
    // there, how many sync-low cycles in a row, and the expected outputs.
    int          m_mode;      // 0 reset, 1 train, 2 wait sync, 3 active
    int          m_time;
    int          m_lost;
    int          m_retrains;
    logic [31:0] e_tx_data;
    logic        e_tx_valid;
    logic [31:0] e_rc_data;
    logic        e_rc_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_retrain();
`ifdef PHY_LINK_CTRL_STATS_EN
        return 32'(m_retrains);
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_mode     = 0;
        m_time     = 0;
        m_lost     = 0;
        m_retrains = 0;
        e_tx_data  = 32'd0;
        e_tx_valid = 1'b0;
        e_rc_data  = 32'd0;
        e_rc_valid = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] d, input logic s);
        int nxt;
        logic retrain;
        // Where the word goes depends on the mode before this edge.
        if (m_mode == 3) begin
            e_tx_valid = v;
            e_tx_data  = v ? d : COM;
            e_rc_valid = 1'b0;
        end else begin
            e_tx_valid = 1'b0;
            e_tx_data  = (m_mode == 0) ? 32'd0 : COM;
            e_rc_valid = v;
            if (v) e_rc_data = d;
        end
        nxt     = m_mode;
        retrain = 1'b0;
        if (m_mode == 0) begin
            nxt = 1;
        end else if (m_mode == 1) begin
            if (m_time + 1 >= IDLE_WORDS) nxt = 2;
        end else if (m_mode == 2) begin
            if (s) nxt = 3;
            else if (m_time + 1 >= SYNC_TMO) begin nxt = 1; retrain = 1'b1; end
        end else begin
            m_lost = s ? 0 : m_lost + 1;
            if (m_lost >= LOSS_TH) begin nxt = 1; retrain = 1'b1; end
        end
        if (retrain && m_retrains < 255) m_retrains++;
        if (nxt != m_mode) begin
            m_mode = nxt;
            m_time = 0;
            m_lost = 0;
        end else begin
            m_time++;
        end
    endtask

    task automatic compare_all();
        check("state",         32'(state),         32'(m_mode));
        check("active",        32'(active),        32'(m_mode == 3));
        check("tx_data",       tx_data,            e_tx_data);
        check("tx_valid",      32'(tx_valid),      32'(e_tx_valid));
        check("recirc_data",   recirc_data,        e_rc_data);
        check("recirc_valid",  32'(recirc_valid),  32'(e_rc_valid));
        check("retrain_count", 32'(retrain_count), exp_retrain());
    endtask

    // One clock: drive on the falling edge, advance the model on the rising
    // edge, compare shortly after it.
    task automatic cycle(input logic v, input logic [31:0] d, input logic s);
        @(negedge clk_2f);
        valid_in   = v;
        data_in    = d;
        rx_sync_in = s;
        @(posedge clk_2f);
        if (reset) model_reset();
        else       model_step(v, d, s);
        #1;
        compare_all();
    endtask

    // Assert reset between edges and check that outputs clear at once.
    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        cycle(1'b0, 32'd0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic sync_lvl;
        model_reset();

        // Reset state
        cycle(1'b0, 32'd0, 1'b1);
        check("pin_reset_state", 32'(state), 32'd0);
        check("pin_reset_tx", tx_data, 32'd0);
        cycle(1'b0, 32'd0, 1'b1);
        reset = 1'b0;

        // Bring-up: state 1,1,1,1,2,3 after release; one diverted word at edge 3
        for (int i = 1; i <= 6; i++) begin
            if (i == 3) cycle(1'b1, 32'h0321AE4F, 1'b1);
            else        cycle(1'b0, 32'hDEAD0000, 1'b1);
            check("pin_bringup_state", 32'(state), (i <= 4) ? 32'd1 : (i == 5) ? 32'd2 : 32'd3);
            check("pin_bringup_txv", 32'(tx_valid), 32'd0);
            if (i == 3) begin
                check("pin_recirc_valid", 32'(recirc_valid), 32'd1);
                check("pin_recirc_data", recirc_data, 32'h0321AE4F);
            end
            if (i >= 2) check("pin_bringup_com", tx_data, COM);
        end
        check("pin_active_6th", 32'(active), 32'd1);

        // ACTIVE traffic: valid word then COM
        cycle(1'b1, 32'h002F190A, 1'b1);
        check("pin_tx_word", tx_data, 32'h002F190A);
        check("pin_tx_valid", 32'(tx_valid), 32'd1);
        check("pin_no_recirc", 32'(recirc_valid), 32'd0);
        cycle(1'b0, 32'h0025780A, 1'b1);
        check("pin_tx_com", tx_data, COM);
        check("pin_tx_idle", 32'(tx_valid), 32'd0);

        // Reset while a word is in flight on tx
        cycle(1'b1, 32'h12345678, 1'b1);
        check("pin_pre_reset_txv", 32'(tx_valid), 32'd1);
        async_reset();
        check("pin_post_reset_state", 32'(state), 32'd0);

        // Sync never arrives: 4 TRAIN + 16 WAIT_SYNC cycles then back to TRAIN
        for (int i = 1; i <= 21; i++) begin
            cycle(1'b0, 32'd0, 1'b0);
            if (i == 5 || i == 20) check("pin_wait_state", 32'(state), 32'd2);
        end
        check("pin_timeout_state", 32'(state), 32'd1);
`ifdef PHY_LINK_CTRL_STATS_EN
        check("pin_timeout_retrain", 32'(retrain_count), 32'd1);
`else
        check("pin_timeout_retrain", 32'(retrain_count), 32'd0);
`endif

        // Back to ACTIVE, then a 2-cycle glitch (survives) and 3-cycle drop (retrains)
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'd0, 1'b1);
        check("pin_reactive", 32'(state), 32'd3);
        cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b0, 32'd0, 1'b1);
        check("pin_glitch_kept", 32'(state), 32'd3);
        cycle(1'b1, 32'hA5A5A5A5, 1'b0);
        cycle(1'b1, 32'h5A5A5A5A, 1'b0);
        check("pin_drop2_state", 32'(state), 32'd3);
        cycle(1'b1, 32'hCAFEF00D, 1'b0);
        check("pin_drop3_state", 32'(state), 32'd1);
        check("pin_exit_word_on_tx", tx_data, 32'hCAFEF00D);
`ifdef PHY_LINK_CTRL_STATS_EN
        check("pin_drop3_retrain", 32'(retrain_count), 32'd2);
`else
        check("pin_drop3_retrain", 32'(retrain_count), 32'd0);
`endif

        // Randomized traffic with a slowly toggling sync level and glitches
        sync_lvl = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            logic s;
            if ($urandom_range(0, 19) == 0) sync_lvl = ~sync_lvl;
            s = sync_lvl;
            if ($urandom_range(0, 9) == 0) s = ~s;
            cycle(1'($urandom_range(0, 1)), $urandom, s);
            if ($urandom_range(0, 799) == 0) async_reset();
        end

        // Sustained sync loss drives the retrain count past saturation
        for (int i = 0; i < 5400; i++) cycle(1'($urandom_range(0, 1)), $urandom, 1'b0);
`ifdef PHY_LINK_CTRL_STATS_EN
        check("pin_retrain_saturated", 32'(retrain_count), 32'd255);
`else
        check("pin_retrain_off", 32'(retrain_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
